// File: rtl/audio_pkg.sv
// Shared definitions for the audio decimator.
//   PCM_W    : width of the PCM samples on both sides of the decimator
//   PHASE_W  : width of the fractional phase accumulator
//   sat16()  : clamps a 17-bit signed value into the signed 16-bit PCM range
package audio_pkg;

  localparam int PCM_W   = 16;
  localparam int PHASE_W = 32;

  function automatic logic [PCM_W-1:0] sat16(input logic signed [PCM_W:0] v);
    if (v > 17'sd32767) begin
      return 16'h7FFF;
    end else if (v < -17'sd32768) begin
      return 16'h8000;
    end else begin
      return v[PCM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_iir_lp.sv
// First-order IIR low-pass, y += ((x << SHIFT) - y) >>> SHIFT, alpha = 2^-SHIFT.
// The state carries SHIFT fraction bits so small steps are not lost.
// Ports:
//   clk    in   core clock
//   reset  in   synchronous, active-high; clears the state
//   en     in   a new input sample is present this cycle
//   x      in   signed 16-bit PCM input
//   y      out  signed filter state, 16 integer bits + SHIFT fraction bits
module audio_iir_lp
  import audio_pkg::*;
#(
  parameter int SHIFT = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PCM_W-1:0]      x,
  output logic [PCM_W-1+SHIFT:0] y
);

  logic signed [PCM_W-1+SHIFT:0] y_q, y_d;
  logic signed [PCM_W+SHIFT:0]   x_ext;
  logic signed [PCM_W+SHIFT:0]   diff;
  logic signed [PCM_W+SHIFT:0]   step;

  // One extra bit over the state width keeps the difference of two
  // full-scale values (e.g. +max input against -max state) from wrapping.
  assign x_ext = $signed({{(SHIFT+1){x[PCM_W-1]}}, x}) <<< SHIFT;
  assign diff  = x_ext - $signed({y_q[PCM_W-1+SHIFT], y_q});
  // Arithmetic shift floors, so a falling input always reaches the target
  // exactly while a rising one settles just below it.
  assign step  = diff >>> SHIFT;

  always_comb begin
    y_d = y_q + $signed(step[PCM_W-1+SHIFT:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
    end else if (en) begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/audio_decimator.sv
// Audio decimator: converts core-rate PCM (any cycle flagged by in_valid)
// into a steady SAMPLERATE stream for the HDMI audio path. A fractional
// phase accumulator produces exactly SAMPLERATE ticks per CLK_HZ cycles; a
// per-channel first-order IIR low-pass limits aliasing; on each tick the
// filter state is truncated into the held output registers.
// Optional build macro AUDIO_DECIMATOR_DITHER_EN: adds rectangular dither
// from a 32-bit Galois LFSR before truncation, with saturation.
// Ports:
//   clk       in   core clock
//   reset     in   synchronous, active-high
//   in_valid  in   audio_l/audio_r carry a new sample this cycle
//   audio_en  in   0 forces muted (zero) output samples
//   audio_l   in   signed PCM, left
//   audio_r   in   signed PCM, right
//   out_stb   out  one-cycle pulse; out_l/out_r updated this cycle
//   out_l     out  signed PCM, left, held between strobes
//   out_r     out  signed PCM, right, held between strobes
module audio_decimator
  import audio_pkg::*;
#(
  parameter int CLK_HZ     = 28000000,
  parameter int SAMPLERATE = 44100,
  parameter int SHIFT      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             audio_en,
  input  logic [PCM_W-1:0] audio_l,
  input  logic [PCM_W-1:0] audio_r,
  output logic             out_stb,
  output logic [PCM_W-1:0] out_l,
  output logic [PCM_W-1:0] out_r
);

  localparam logic [PHASE_W:0] SR_W  = (PHASE_W+1)'(SAMPLERATE);
  localparam logic [PHASE_W:0] CLK_W = (PHASE_W+1)'(CLK_HZ);

  logic [PHASE_W-1:0]     acc_q, acc_d;
  logic [PHASE_W:0]       acc_sum;
  logic                   tick_q, tick_d;
  logic                   out_stb_q;
  logic [PCM_W-1:0]       out_l_q, out_l_d;
  logic [PCM_W-1:0]       out_r_q, out_r_d;
  logic [PCM_W-1+SHIFT:0] y_l, y_r;
  logic [PCM_W-1:0]       smp_l, smp_r;

  audio_iir_lp #(.SHIFT(SHIFT)) u_iir_l (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid),
    .x     (audio_l),
    .y     (y_l)
  );

  audio_iir_lp #(.SHIFT(SHIFT)) u_iir_r (
    .clk   (clk),
    .reset (reset),
    .en    (in_valid),
    .x     (audio_r),
    .y     (y_r)
  );

  // Phase accumulator: computed one bit wider so the compare never wraps.
  always_comb begin
    acc_sum = {1'b0, acc_q} + SR_W;
    tick_d  = 1'b0;
    acc_d   = acc_sum[PHASE_W-1:0];
    if (acc_sum >= CLK_W) begin
      tick_d = 1'b1;
      acc_d  = PHASE_W'(acc_sum - CLK_W);
    end
  end

`ifdef AUDIO_DECIMATOR_DITHER_EN
  logic [PHASE_W-1:0]           lfsr_q;
  logic signed [PCM_W+SHIFT:0]  dith_l, dith_r;
  logic                         unused_dith;

  // Adding 0..2^SHIFT-1 fraction LSBs before the floor gives rectangular
  // dither of one output LSB; the slice above SHIFT is the floored result.
  assign dith_l = $signed({y_l[PCM_W-1+SHIFT], y_l})
                + $signed({{(PCM_W+1){1'b0}}, lfsr_q[SHIFT-1:0]});
  assign dith_r = $signed({y_r[PCM_W-1+SHIFT], y_r})
                + $signed({{(PCM_W+1){1'b0}}, lfsr_q[SHIFT-1:0]});
  assign smp_l  = sat16(dith_l[PCM_W+SHIFT:SHIFT]);
  assign smp_r  = sat16(dith_r[PCM_W+SHIFT:SHIFT]);
  assign unused_dith = ^{dith_l[SHIFT-1:0], dith_r[SHIFT-1:0]};

  // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1, stepped per output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 32'h1;
    end else if (tick_q) begin
      lfsr_q <= {1'b0, lfsr_q[PHASE_W-1:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    end
  end
`else
  logic unused_frac;

  assign smp_l = y_l[PCM_W-1+SHIFT:SHIFT];
  assign smp_r = y_r[PCM_W-1+SHIFT:SHIFT];
  assign unused_frac = ^{y_l[SHIFT-1:0], y_r[SHIFT-1:0]};
`endif

  // Muting zeroes only the latched sample; the filters keep tracking so
  // un-muting resumes from the settled value.
  always_comb begin
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    if (tick_q) begin
      out_l_d = audio_en ? smp_l : '0;
      out_r_d = audio_en ? smp_r : '0;
    end
  end

  // The filter state used here is the one registered during the tick
  // cycle, so a coincident in_valid update is not yet visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      tick_q    <= 1'b0;
      out_stb_q <= 1'b0;
      out_l_q   <= '0;
      out_r_q   <= '0;
    end else begin
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      out_stb_q <= tick_q;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
    end
  end

  assign out_stb = out_stb_q;
  assign out_l   = out_l_q;
  assign out_r   = out_r_q;

endmodule

// File: tb/tb_audio_decimator.sv
// Bench for audio_decimator. Three instances share clock, reset and inputs:
//   u_a : CLK_HZ=441000, SAMPLERATE=44100 (integer ratio, strobe every 10)
//   u_b : CLK_HZ=100,    SAMPLERATE=30    (fractional ratio)
//   u_c : CLK_HZ=1,      SAMPLERATE=1     (strobe every cycle, exposes y)
// All use SHIFT=2.
module tb_audio_decimator;

  logic        clk = 1'b0;
  logic        reset, in_valid, audio_en;
  logic [15:0] audio_l, audio_r;
  logic        stb_a, stb_b, stb_c;
  logic [15:0] l_a, r_a, l_b, r_b, l_c, r_c;

  always #5 clk = ~clk;

  audio_decimator #(.CLK_HZ(441000), .SAMPLERATE(44100), .SHIFT(2)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .audio_en(audio_en),
    .audio_l(audio_l), .audio_r(audio_r),
    .out_stb(stb_a), .out_l(l_a), .out_r(r_a));

  audio_decimator #(.CLK_HZ(100), .SAMPLERATE(30), .SHIFT(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .audio_en(audio_en),
    .audio_l(audio_l), .audio_r(audio_r),
    .out_stb(stb_b), .out_l(l_b), .out_r(r_b));

  audio_decimator #(.CLK_HZ(1), .SAMPLERATE(1), .SHIFT(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .audio_en(audio_en),
    .audio_l(audio_l), .audio_r(audio_r),
    .out_stb(stb_c), .out_l(l_c), .out_r(r_c));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference filter state (SHIFT=2), plus the value it held before the last edge.
  int ym_l = 0, ym_r = 0, yp_l = 0, yp_r = 0;

  typedef struct {
    logic        v;
    logic        en;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] tr(input int y);
    int t;
    t = y >>> 2;
    return t[15:0];
  endfunction

  task automatic step();
    int xl, xr;
    yp_l = ym_l;
    yp_r = ym_r;
    xl = int'($signed(audio_l));
    xr = int'($signed(audio_r));
    @(posedge clk);
    if (reset) begin
      ym_l = 0;
      ym_r = 0;
    end else if (in_valid) begin
      ym_l = ym_l + ((xl * 4 - ym_l) >>> 2);
      ym_r = ym_r + ((xr * 4 - ym_r) >>> 2);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int cnt_b, cnt_a, prev;
    logic found, ea, eb;

    tbl[0] = '{1'b1, 1'b1, 16'h1000, 16'hF000, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h1000, 16'hF000, 16'h0400, 16'hFC00};
    tbl[2] = '{1'b1, 1'b1, 16'h1000, 16'hF000, 16'h0700, 16'hF900};
    tbl[3] = '{1'b0, 1'b1, 16'h1000, 16'hF000, 16'h0940, 16'hF6C0};
    tbl[4] = '{1'b0, 1'b0, 16'h1000, 16'hF000, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 16'h1000, 16'hF000, 16'h0000, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 16'h1000, 16'hF000, 16'h0AF0, 16'hF510};

    // Reset with live input: in_valid must be ignored while reset is high.
    reset = 1'b1; in_valid = 1'b1; audio_en = 1'b1;
    audio_l = 16'h7FFF; audio_r = 16'h8000;
    step(); step(); step();
    check("rst_stb_a", stb_a, 1'b0);
    check("rst_l_a", l_a, 16'h0);
    check("rst_r_a", r_a, 16'h0);
    check("rst_stb_c", stb_c, 1'b0);

    // Cadence: integer and fractional ratios from reset release.
    in_valid = 1'b0; audio_l = 16'h0; audio_r = 16'h0;
    reset = 1'b0;
    cnt_b = 0;
    for (int k = 1; k <= 101; k++) begin
      step();
      ea = (k >= 11) && ((k - 1) % 10 == 0);
      eb = (k >= 5) && (((k - 1) % 10 == 4) || ((k - 1) % 10 == 7) || ((k - 1) % 10 == 0));
      check($sformatf("cad_a_k%0d", k), stb_a, ea);
      check($sformatf("cad_b_k%0d", k), stb_b, eb);
      check($sformatf("cad_c_k%0d", k), stb_c, (k >= 2));
      if (k >= 2 && stb_b) cnt_b++;
    end
    check("frac_count_100", cnt_b, 30);
    check("c_out_zero_after_rst", l_c, 16'h0);

    // Filter step table on u_c: each output is the y held before that edge.
    do_reset();
    in_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v; audio_en = tbl[i].en;
      audio_l  = tbl[i].l; audio_r  = tbl[i].r;
      step();
      check($sformatf("tbl%0d_stb", i), stb_c, 1'b1);
      check($sformatf("tbl%0d_l", i), l_c, tbl[i].el);
      check($sformatf("tbl%0d_r", i), r_c, tbl[i].er);
    end

    // Rising step settles where the floored update stalls: y = 4*0x1000-3.
    in_valid = 1'b1; audio_en = 1'b1; audio_l = 16'h1000;
    for (int i = 0; i < 40; i++) step();
    check("conv_l_1000", l_c, 16'h0FFF);

    // Full negative scale: monotonic descent to exactly 0x8000, no wrap.
    audio_l = 16'h8000;
    prev = int'($signed(l_c));
    for (int i = 0; i < 80; i++) begin
      step();
      check($sformatf("nowrap_%0d", i), (int'($signed(l_c)) <= prev), 1'b1);
      prev = int'($signed(l_c));
    end
    check("neg_full_scale", l_c, 16'h8000);

    // Mute on u_a: strobes keep coming with zero data, filter keeps running.
    do_reset();
    in_valid = 1'b1; audio_en = 1'b0; audio_l = 16'h7FFF; audio_r = 16'h8000;
    cnt_a = 0;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (stb_a) begin
        cnt_a++;
        check($sformatf("mute_l_k%0d", k), l_a, 16'h0);
        check($sformatf("mute_r_k%0d", k), r_a, 16'h0);
      end
    end
    check("mute_strobes", cnt_a, 3);
    audio_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (stb_a) found = 1'b1;
    end
    check("unmute_stb_seen", found, 1'b1);
    check("unmute_l", l_a, tr(yp_l));
    check("unmute_r", r_a, tr(yp_r));
    check("unmute_nonzero", (l_a != 16'h0), 1'b1);

    // Reset in the tick cycle: strobe dropped, outputs cleared, phase restarts.
    for (int i = 0; i < 9; i++) step();
    check("pre_rst_no_stb", stb_a, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_stb", stb_a, 1'b0);
    check("midrst_l", l_a, 16'h0);
    check("midrst_r", r_a, 16'h0);
    reset = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("restart_k%0d", k), stb_a, (k == 11));
    end
    check("restart_l", l_a, tr(yp_l));

    // Small constant and near-full-scale constant.
    do_reset();
    in_valid = 1'b1; audio_en = 1'b1; audio_l = 16'h0100; audio_r = 16'h7FFF;
    for (int i = 0; i < 60; i++) step();
    for (int i = 0; i < 20; i++) begin
      step();
`ifdef AUDIO_DECIMATOR_DITHER_EN
      check($sformatf("dith_l_%0d", i), (l_c >= 16'h00FF && l_c <= 16'h0101), 1'b1);
      check($sformatf("dith_r_%0d", i), r_c[15], 1'b0);
`else
      check($sformatf("const_l_%0d", i), l_c, 16'h00FF);
      check($sformatf("const_r_%0d", i), r_c, 16'h7FFE);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
